trivium_keystream_ctrl: RTL and testbench

//  Sequencer for the Trivium datapath (trivium_wrapper). Accepts a key/IV/block-count job,

---
 rtl/trivium_ctrl_pkg.sv | 13 +
 rtl/trivium_keystream_ctrl.sv | 157 +++++++++++++++
 tb/tb_trivium_keystream_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_ctrl_pkg.sv
// Shared state encoding and default sizes for the Trivium keystream sequencer.
package trivium_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, RST, WAIT, HOLD, DONE} state_t;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_KEY_W          = 80;
    localparam int DEF_IV_W           = 80;
    localparam int DEF_CNT_W          = 16;
    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/trivium_keystream_ctrl.sv
// Job sequencer for the Trivium core: pulses core reset, harvests N blocks, streams them out.
// Optional per-block watchdog enabled by defining TRIVIUM_CTRL_TIMEOUT_EN.
module trivium_keystream_ctrl
    import trivium_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int IV_W       = DEF_IV_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
`ifdef TRIVIUM_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [KEY_W-1:0]      key_i,
    input  logic [IV_W-1:0]       iv_i,
    input  logic [CNT_W-1:0]      n_blocks_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  ks_valid_o,
    input  logic                  ks_ready_i,
    output logic [DATA_WIDTH-1:0] ks_data_o,
    output logic                  ks_last_o,
    output logic                  uut_rst_o,
    output logic [KEY_W-1:0]      uut_key_o,
    output logic [IV_W-1:0]       uut_iv_o,
    output logic                  uut_next_o,
    input  logic                  uut_end_i,
    input  logic [DATA_WIDTH-1:0] uut_block_i
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q;
    logic [CNT_W-1:0]  cnt_q, n_q;
    logic              end_q;
    logic              end_rise;
    logic              rst_done;
    logic              wd_expired;

    // end_q resets high so a level already present when the core leaves reset is not an edge
    assign end_rise = uut_end_i && !end_q;
    assign rst_done = (rst_cnt_q == RC_W'(RST_CYCLES - 1));

`ifdef TRIVIUM_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign wd_expired = (state_q == WAIT) && !end_rise && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign err_o      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == WAIT && !wd_expired) ? wd_q + WD_W'(1) : '0;
            if (state_q == IDLE && start_i)
                err_q <= 1'b0;
            else if (wd_expired)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        unique case (state_q)
            IDLE: if (start_i) state_d = (n_blocks_i == '0) ? DONE : RST;
            RST:  if (rst_done) state_d = WAIT;
            WAIT: begin
                if (end_rise)
                    state_d = HOLD;
                else if (wd_expired)
                    state_d = DONE;
            end
            HOLD: if (ks_ready_i) state_d = ks_last_o ? DONE : WAIT;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q  <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            end_q      <= 1'b1;
            uut_rst_o  <= 1'b1;
            uut_key_o  <= '0;
            uut_iv_o   <= '0;
            uut_next_o <= 1'b0;
            ks_valid_o <= 1'b0;
            ks_data_o  <= '0;
            ks_last_o  <= 1'b0;
        end else begin
            end_q      <= uut_end_i;
            uut_next_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        uut_key_o <= key_i;
                        uut_iv_o  <= iv_i;
                        n_q       <= n_blocks_i;
                        cnt_q     <= '0;
                        rst_cnt_q <= '0;
                    end
                end
                RST: begin
                    if (rst_done)
                        uut_rst_o <= 1'b0;
                    else
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                end
                WAIT: begin
                    if (end_rise) begin
                        ks_data_o  <= uut_block_i;
                        ks_valid_o <= 1'b1;
                        ks_last_o  <= (cnt_q == n_q - CNT_W'(1));
                    end
                end
                HOLD: begin
                    // next block is requested only once the holding register has drained
                    if (ks_ready_i) begin
                        ks_valid_o <= 1'b0;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (!ks_last_o)
                            uut_next_o <= 1'b1;
                    end
                end
                DONE: uut_rst_o <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_keystream_ctrl.sv
// Randomized bench for trivium_keystream_ctrl with a behavioural core model and a block scoreboard.
module tb_trivium_keystream_ctrl;

    localparam int KW = 80;
    localparam int IW = 80;
    localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [KW-1:0] key_i = '0;
    logic [IW-1:0] iv_i = '0;
    logic [15:0]   n_blocks_i = '0;
    logic          ks_ready_i = 1'b1;
    logic          uut_end_i = 1'b0;
    logic [63:0]   uut_block_i = '0;
    logic          busy_o, done_o, err_o, ks_valid_o, ks_last_o, uut_rst_o, uut_next_o;
    logic [63:0]   ks_data_o;
    logic [KW-1:0] uut_key_o;
    logic [IW-1:0] uut_iv_o;

    trivium_keystream_ctrl #(
        .DATA_WIDTH(64), .KEY_W(KW), .IV_W(IW), .CNT_W(16), .RST_CYCLES(4)
`ifdef TRIVIUM_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
        .n_blocks_i(n_blocks_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i), .ks_data_o(ks_data_o),
        .ks_last_o(ks_last_o), .uut_rst_o(uut_rst_o), .uut_key_o(uut_key_o),
        .uut_iv_o(uut_iv_o), .uut_next_o(uut_next_o), .uut_end_i(uut_end_i),
        .uut_block_i(uut_block_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [KW-1:0] m_key = '0;
    logic [IW-1:0] m_iv = '0;
    logic        m_err = 1'b0;
    int          job_beats = 0, job_next = 0, job_done = 0, job_last = 0;
    logic [63:0] job_data[8];
    int          rdy_mode = 0;
    int          stall_cnt = 0;
    int          init_cyc = 20;
    logic        core_mute = 1'b0;
    logic        timeout_job = 1'b0;
    int          tmr = 0;
    int          cidx = 0;

    function automatic logic [63:0] blk_fn(input logic [KW-1:0] k, input logic [IW-1:0] v, input int i);
        logic [63:0] m;
        m = GOLD * 64'(i + 1);
        return k[63:0] ^ {v[15:0], v[79:32]} ^ m;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Core model: init delay after reset release, then a fresh block per next request.
    initial forever begin
        @(posedge clk);
        if (uut_rst_o || core_mute) begin
            uut_end_i <= 1'b0;
            tmr       <= init_cyc;
            cidx      <= 0;
        end else if (uut_next_o) begin
            uut_end_i <= 1'b0;
            tmr       <= int'($urandom_range(1, 6));
            cidx      <= cidx + 1;
        end else if (!uut_end_i) begin
            if (tmr == 0) begin
                uut_end_i   <= 1'b1;
                uut_block_i <= blk_fn(uut_key_o, uut_iv_o, cidx);
            end else begin
                tmr <= tmr - 1;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: ks_ready_i = 1'b1;
            1: ks_ready_i = ($urandom_range(0, 99) < 60);
            2: begin
                if (ks_valid_o && job_beats == 0 && stall_cnt < 5) begin
                    ks_ready_i = 1'b0;
                    stall_cnt++;
                end else begin
                    ks_ready_i = 1'b1;
                end
            end
            default: ks_ready_i = (job_beats == 0);
        endcase
    end

    // Per-cycle compare against the scoreboard and the stream rules
    initial begin
        logic        pv, pr, pl, pdn;
        logic [63:0] pd;
        pv = 0; pr = 0; pl = 0; pdn = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", 128'(busy_o), 128'(0));
                chk("rst_valid", 128'(ks_valid_o), 128'(0));
                chk("rst_uut_rst", 128'(uut_rst_o), 128'(1));
                chk("rst_next", 128'(uut_next_o), 128'(0));
                chk("rst_err", 128'(err_o), 128'(0));
                pv = 0; pdn = 0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 128'(ks_valid_o), 128'(1));
                    chk("hold_data", 128'(ks_data_o), 128'(pd));
                    chk("hold_last", 128'(ks_last_o), 128'(pl));
                end
                if (pdn) chk("busy_after_done", 128'(busy_o), 128'(0));
                if (uut_next_o) begin
                    chk("next_while_valid", 128'(ks_valid_o), 128'(0));
                    job_next++;
                end
                if (busy_o) begin
                    chk("uut_key", 128'(uut_key_o), 128'(m_key));
                    chk("uut_iv", 128'(uut_iv_o), 128'(m_iv));
                end
                if (ks_valid_o && ks_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 128'(ks_valid_o), 128'(0));
                    end else begin
                        chk("ks_data", 128'(ks_data_o), 128'(exp_q[0]));
                        chk("ks_last", 128'(ks_last_o), 128'(exp_q.size() == 1));
                        void'(exp_q.pop_front());
                    end
                    if (job_beats < 8) job_data[job_beats] = ks_data_o;
                    job_beats++;
                    if (ks_last_o) job_last++;
                end
                if (done_o) begin
                    job_done++;
                    if (timeout_job) begin
                        m_err = 1'b1;
                        exp_q.delete();
                    end else begin
                        chk("done_all_beats", 128'(exp_q.size()), 128'(0));
                    end
                end
`ifdef TRIVIUM_CTRL_TIMEOUT_EN
                chk("err", 128'(err_o), 128'(m_err));
`else
                chk("err_tied", 128'(err_o), 128'(0));
`endif
                pv = ks_valid_o; pr = ks_ready_i; pd = ks_data_o; pl = ks_last_o; pdn = done_o;
            end
        end
    end

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy_o && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        chk("idle_before_start", 128'(busy_o), 128'(0));
    endtask

    task automatic start_job(input logic [KW-1:0] k, input logic [IW-1:0] v, input logic [15:0] n);
        wait_idle();
        key_i = k; iv_i = v; n_blocks_i = n; start_i = 1'b1;
        m_key = k; m_iv = v;
        exp_q.delete();
        for (int j = 0; j < int'(n); j++) exp_q.push_back(blk_fn(k, v, j));
        job_beats = 0; job_next = 0; job_done = 0; job_last = 0;
        @(posedge clk); #1;
        start_i = 1'b0;
        m_err = 1'b0;
        key_i = {16'($urandom), $urandom, $urandom};
        n_blocks_i = 16'($urandom);
    endtask

    task automatic wait_done(input int bound, input bit noise);
        int c;
        c = 0;
        while (job_done == 0 && c < bound) begin
            if (noise && busy_o && $urandom_range(0, 9) == 0) begin
                start_i = 1'b1;
                key_i = {16'($urandom), $urandom, $urandom};
                iv_i = {16'($urandom), $urandom, $urandom};
                n_blocks_i = 16'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        start_i = 1'b0;
        chk("done_within_bound", 128'(job_done), 128'(1));
    endtask

    task automatic end_job(input int n);
        chk("beats", 128'(job_beats), 128'(n));
        chk("next_pulses", 128'(job_next), 128'((n > 0) ? n - 1 : 0));
        chk("last_flags", 128'(job_last), 128'(n > 0));
        chk("done_pulses", 128'(job_done), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uut_rst", 128'(uut_rst_o), 128'(1));
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_data", 128'(ks_data_o), 128'(0));
        chk("reset_key", 128'(uut_key_o), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // three blocks, always ready, zero key/iv so the blocks are known constants
        rdy_mode = 0; init_cyc = 20;
        start_job('0, '0, 16'd3);
        wait_done(2000, 0);
        end_job(3);
        chk("t1_block0", 128'(job_data[0]), 128'(64'h9E3779B97F4A7C15));
        chk("t1_block2", 128'(job_data[2]), 128'(64'hDAA66D2C7DDF743F));
        @(negedge clk);
        chk("t1_busy_low", 128'(busy_o), 128'(0));
        @(posedge clk); #1;

        // back-pressure on the first beat
        rdy_mode = 2; stall_cnt = 0; init_cyc = 7;
        start_job(80'h1, '0, 16'd2);
        wait_done(2000, 0);
        end_job(2);
        chk("t2_block0", 128'(job_data[0]), 128'(64'h9E3779B97F4A7C14));
        chk("t2_stalls", 128'(stall_cnt), 128'(5));

        // empty job: core never leaves reset
        rdy_mode = 0;
        start_job({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 16'd0);
        @(negedge clk);
        chk("n0_done", 128'(done_o), 128'(1));
        chk("n0_uut_rst", 128'(uut_rst_o), 128'(1));
        @(posedge clk); #1;
        chk("n0_uut_rst_after", 128'(uut_rst_o), 128'(1));
        wait_done(10, 0);
        end_job(0);

        // random jobs with ignored start pulses and n_blocks churn
        for (int it = 0; it < 12; it++) begin
            int n;
            rdy_mode = 1;
            init_cyc = int'($urandom_range(5, 30));
            n = int'($urandom_range(1, 6));
            start_job({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 16'(n));
            wait_done(3000, 1);
            end_job(n);
        end

        // async reset while beat 2 of 4 waits in the holding register
        rdy_mode = 3; init_cyc = 9;
        start_job({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 16'd4);
        begin
            int c;
            c = 0;
            while (!(ks_valid_o && job_beats == 1) && c < 500) begin
                @(posedge clk); #1;
                c++;
            end
            chk("t5_reached_beat2", 128'(ks_valid_o && job_beats == 1), 128'(1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 128'(ks_valid_o), 128'(0));
        chk("t5_busy", 128'(busy_o), 128'(0));
        chk("t5_data", 128'(ks_data_o), 128'(0));
        chk("t5_uut_rst", 128'(uut_rst_o), 128'(1));
        chk("t5_key", 128'(uut_key_o), 128'(0));
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_done", 128'(job_done), 128'(0));

        // core that never reports end_block
        core_mute = 1'b1;
        timeout_job = 1'b1;
        start_job({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 16'd2);
`ifdef TRIVIUM_CTRL_TIMEOUT_EN
        begin
            int c;
            c = 0;
            while (job_done == 0 && c < 200) begin
                @(posedge clk); #1;
                c++;
            end
            chk("wd_window", 128'(c >= 66 && c <= 72), 128'(1));
        end
        chk("wd_err", 128'(err_o), 128'(1));
        chk("wd_no_beats", 128'(job_beats), 128'(0));
        timeout_job = 1'b0;
        core_mute = 1'b0;
        init_cyc = 5;
        start_job({16'($urandom), $urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 16'd1);
        chk("wd_err_cleared", 128'(err_o), 128'(0));
        wait_done(2000, 0);
        end_job(1);
`else
        repeat (150) @(posedge clk);
        #1;
        chk("nowd_busy", 128'(busy_o), 128'(1));
        chk("nowd_err", 128'(err_o), 128'(0));
        chk("nowd_no_done", 128'(job_done), 128'(0));
        rst_n = 1'b0;
        exp_q.delete();
        timeout_job = 1'b0;
        core_mute = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
